// File: rtl/vector_order_deser.sv
// Serial-in, parallel-out word assembler with elaboration-time bit-order mapping.
// Presents each completed word on a descending view and a bit-reversed view behind valid/ready.
module vector_order_deser #(
    parameter int WIDTH     = 14,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic             s_bit,
    input  logic             s_sof,
    output logic             p_valid,
    input  logic             p_ready,
    output logic [WIDTH-1:0] p_data,
    output logic [WIDTH-1:0] p_data_rev,
    output logic             ovf,
    output logic             frame_err
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt, k, pos;
    logic [WIDTH-1:0] sreg, sreg_nxt, word_rev;
    logic             take, done, ferr_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sreg_nxt  = sreg;
        take      = 1'b0;
        done      = 1'b0;
        ferr_nxt  = 1'b0;
        // A start-of-frame bit is always bit 0, even if it would have completed a word.
        k   = s_sof ? '0 : cnt;
        pos = MSB_FIRST ? (LAST - k) : k;
        case (state)
            IDLE:    take = s_valid && s_sof;
            COLLECT: begin
                take     = s_valid;
                ferr_nxt = s_valid && s_sof && (cnt != '0);
            end
            default: state_nxt = IDLE;
        endcase
        if (take) begin
            if (s_sof)
                sreg_nxt = '0;
            sreg_nxt[pos] = s_bit;
            if (k == LAST) begin
                done      = 1'b1;
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end else begin
                cnt_nxt   = k + CW'(1);
                state_nxt = COLLECT;
            end
        end
    end

    always_comb begin
        word_rev = '0;
        for (int i = 0; i < WIDTH; i++)
            word_rev[i] = sreg_nxt[WIDTH-1-i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sreg       <= '0;
            p_valid    <= 1'b0;
            p_data     <= '0;
            p_data_rev <= '0;
            ovf        <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            sreg      <= sreg_nxt;
            frame_err <= ferr_nxt;
            if (done) begin
                // A held, unaccepted word wins; the newcomer is dropped and flagged.
                if (!p_valid || p_ready) begin
                    p_data     <= sreg_nxt;
                    p_data_rev <= word_rev;
                    p_valid    <= 1'b1;
                end else begin
                    ovf <= 1'b1;
                end
            end else if (p_ready) begin
                p_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/vector_order_deser.md
Name: vector_order_deser

Overview:
- Serial-in, parallel-out word assembler with a configurable bit-order mapping.
- Sits on the receive side of the packed-vector path. It rebuilds a WIDTH-bit word from a serial bit stream.
- Presents the word on two views:
  - p_data: descending-index view.
  - p_data_rev: ascending-equivalent, bit-reversed view.
- Output uses a valid/ready handshake, with overflow and framing-error reporting.

Parameters:
- WIDTH, 14, word length in bits; legal range 2..64.
- MSB_FIRST, 1, 1: first received bit lands in p_data[WIDTH-1]; 0: first received bit lands in p_data[0].

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- s_valid  input  1  serial bit present this cycle; always accepted (no backpressure).
- s_bit  input  1  serial data bit.
- s_sof  input  1  qualifies s_valid; marks this bit as bit 0 of a new word.
- p_valid  output  1  assembled word available.
- p_ready  input  1  consumer accepts the word when p_valid && p_ready.
- p_data  output  WIDTH  assembled word, descending index.
- p_data_rev  output  WIDTH  p_data_rev[i] = p_data[WIDTH-1-i], registered together with p_data.
- ovf  output  1  sticky: a completed word was dropped.
- frame_err  output  1  one-cycle pulse: partial word discarded by a new s_sof.

Behaviour:
- Reset (rst=1 at a clock edge):
  - p_valid=0, p_data=0, p_data_rev=0, ovf=0, frame_err=0.
  - FSM=IDLE, bit counter cnt=0, shift register=0.
  - Reset mid-word or mid-hold discards everything.
- FSM states: IDLE, COLLECT.
  - IDLE:
    - s_valid && !s_sof: bit ignored, no flag.
    - s_valid && s_sof: bit stored as bit k=0, cnt=1, go to COLLECT.
  - COLLECT:
    - s_valid && !s_sof: store bit k=cnt, cnt+=1.
    - s_valid && s_sof: if cnt!=0, discard the partial word and pulse frame_err next cycle. The bit becomes k=0, cnt=1, stay in COLLECT.
    - When bit k=WIDTH-1 is accepted, the word is complete; cnt returns to 0 and the FSM goes to IDLE.
- Bit placement:
  - MSB_FIRST=1: bit k goes to p_data[WIDTH-1-k].
  - MSB_FIRST=0: bit k goes to p_data[k].
  - The mapping is fixed at elaboration. No runtime reordering.
- Output latency: p_valid rises on the edge after the cycle that accepts the final bit, i.e. 1 cycle after the last bit.
- Output register behaviour:
  - p_data and p_data_rev change only on word load or reset.
  - They are stable while p_valid=1 and p_ready=0.
- Handshake:
  - The transfer occurs in a cycle with p_valid && p_ready. p_valid falls next cycle unless a new word loads in that same cycle.
  - Completion with p_valid=0: load word, p_valid=1.
  - Completion with p_valid=1 && p_ready=1: load new word, p_valid stays 1, no overflow.
  - Completion with p_valid=1 && p_ready=0: new word dropped, old word retained, ovf set to 1 (sticky until rst).
- Simultaneous events:
  - s_sof arriving on the bit that would complete a word counts as a restart, not a completion. frame_err pulses.
  - p_ready while p_valid=0 is ignored.
- Serial input continues assembling while the output is held. There is no stall of the input.
- Gaps: s_valid=0 cycles may appear anywhere within a word. cnt holds across them, with no timeout.

Test Plan:
- Reset defaults: assert rst 2 cycles mid-word, then release → p_valid=0, p_data=0, p_data_rev=0, ovf=0, frame_err=0. A following non-sof bit is ignored.
- MSB_FIRST=1, WIDTH=14, p_ready=1: send s_sof then the bits of 14'h2A5C MSB first, back-to-back → p_valid=1 exactly 1 cycle after the 14th bit, p_data=14'h2A5C, p_data_rev=14'h0E95, p_valid=0 the next cycle.
- MSB_FIRST=0: same bit stream as the previous case → p_data=14'h0E95, p_data_rev=14'h2A5C. Repeat with random s_valid gaps → same result.
- Overflow: hold p_ready=0; send word 14'h0001, then word 14'h3FFF → p_data stays 14'h0001 and ovf=1. Raise p_ready → transfer occurs, p_valid=0, ovf remains 1.
- Back-to-back with accept: the final bit of word B (14'h1234) coincides with p_ready=1 on held word A → p_data=14'h1234, p_valid never drops, ovf=0.
- Framing error: send s_sof plus 5 bits, then s_sof plus 14 bits of 14'h0ABC → frame_err high exactly 1 cycle, and the output word is 14'h0ABC.
